// File: rtl/conv_layer_output_collector.sv
// Collects sparse, out-of-order (id, value) beats from the convolutional
// neuron layer into one of two frame banks, then replays each completed
// frame in id order as a first/last-marked stream. One bank collects while
// the other drains.
module conv_layer_output_collector #(
  parameter int LAYER_SIZE       = 10,
  parameter int LAYER_SIZE_ORDER = 4,
  parameter int OUTPUT_WIDTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [OUTPUT_WIDTH-1:0]     in_stream,
  input  logic [LAYER_SIZE_ORDER-1:0] in_id,
  input  logic                        in_valid,
  output logic [OUTPUT_WIDTH-1:0]     out_stream,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        clear_err,
  output logic                        err_range,
  output logic                        err_dup,
  output logic                        err_overflow
);

  localparam logic [LAYER_SIZE_ORDER-1:0] LP_LAST_ID = LAYER_SIZE_ORDER'(LAYER_SIZE);
  localparam logic [LAYER_SIZE_ORDER-1:0] LP_ONE     = LAYER_SIZE_ORDER'(1);
  localparam logic [LAYER_SIZE-1:0]       LP_ALL     = '1;
  localparam logic                        LP_SINGLE  = (LAYER_SIZE == 1);

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  // Frame storage and per-bank received bitmaps (bit i <-> id i+1)
  logic [OUTPUT_WIDTH-1:0]     r_mem [2][LAYER_SIZE];
  logic [LAYER_SIZE-1:0]       r_bitmap [2];
  logic [1:0]                  r_bank_full;
  logic                        r_wr_bank;
  logic                        r_rd_bank;
  logic [LAYER_SIZE_ORDER-1:0] r_rd_idx;
  state_t                      r_state;

  // Registered output beat
  logic [OUTPUT_WIDTH-1:0]     r_out_stream;
  logic                        r_out_first;
  logic                        r_out_last;
  logic                        r_out_valid;

  // Sticky error flags
  logic                        r_err_range;
  logic                        r_err_dup;
  logic                        r_err_overflow;

  // Write-side decode
  logic [LAYER_SIZE_ORDER-1:0] w_in_idx;
  logic                        w_range_ok;
  logic [LAYER_SIZE-1:0]       w_id_mask;
  logic [LAYER_SIZE-1:0]       w_cur_bitmap;
  logic                        w_wr_full;
  logic                        w_set_range;
  logic                        w_set_ovf;
  logic                        w_set_dup;
  logic                        w_wr_en;
  logic                        w_complete;

  // Read-side next-state
  logic                        w_handshake;
  logic                        w_release;
  logic [1:0]                  w_bank_full_nxt;
  state_t                      w_state_nxt;
  logic                        w_rd_bank_nxt;
  logic [LAYER_SIZE_ORDER-1:0] w_rd_idx_nxt;
  logic [OUTPUT_WIDTH-1:0]     w_out_stream_nxt;
  logic                        w_out_first_nxt;
  logic                        w_out_last_nxt;
  logic                        w_out_valid_nxt;

  // Classify the incoming beat in priority order: range, overflow, duplicate, write
  always_comb begin
    w_in_idx     = in_id - LP_ONE;
    w_range_ok   = (in_id != '0) && (in_id <= LP_LAST_ID);
    w_id_mask    = w_range_ok ? (LAYER_SIZE'(1) << w_in_idx) : '0;
    w_cur_bitmap = r_bitmap[r_wr_bank];
    w_wr_full    = r_bank_full[r_wr_bank];
    w_set_range  = in_valid && !w_range_ok;
    w_set_ovf    = in_valid && w_range_ok && w_wr_full;
    w_set_dup    = in_valid && w_range_ok && !w_wr_full && ((w_cur_bitmap & w_id_mask) != '0);
    w_wr_en      = in_valid && w_range_ok && !w_wr_full && ((w_cur_bitmap & w_id_mask) == '0);
    w_complete   = w_wr_en && ((w_cur_bitmap | w_id_mask) == LP_ALL);
  end

  // Merge write-side completion and read-side release into the bank_full update;
  // they always target different banks, so both apply.
  always_comb begin
    w_handshake     = r_out_valid && out_ready;
    w_release       = (r_state == S_DRAIN) && w_handshake && (r_rd_idx == LP_LAST_ID);
    w_bank_full_nxt = r_bank_full;
    if (w_complete) w_bank_full_nxt[r_wr_bank] = 1'b1;
    if (w_release)  w_bank_full_nxt[r_rd_bank] = 1'b0;
  end

  // Read FSM next-state and next output beat
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt      = r_state;
    w_rd_bank_nxt    = r_rd_bank;
    w_rd_idx_nxt     = r_rd_idx;
    w_out_stream_nxt = r_out_stream;
    w_out_first_nxt  = r_out_first;
    w_out_last_nxt   = r_out_last;
    w_out_valid_nxt  = r_out_valid;
    unique case (r_state)
      S_IDLE: begin
        if (r_bank_full[r_rd_bank]) begin
          w_out_stream_nxt = r_mem[r_rd_bank][0];
          w_out_first_nxt  = 1'b1;
          w_out_last_nxt   = LP_SINGLE;
          w_out_valid_nxt  = 1'b1;
          w_rd_idx_nxt     = LP_ONE;
          w_state_nxt      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_handshake) begin
          if (r_rd_idx != LP_LAST_ID) begin
            // r_rd_idx is the id just sent, which is also the array index of the next id
            w_out_stream_nxt = r_mem[r_rd_bank][r_rd_idx];
            w_out_first_nxt  = 1'b0;
            w_out_last_nxt   = ((r_rd_idx + LP_ONE) == LP_LAST_ID);
            w_rd_idx_nxt     = r_rd_idx + LP_ONE;
          end else begin
            w_rd_bank_nxt = ~r_rd_bank;
            if (r_bank_full[~r_rd_bank]) begin
              // Other frame already waiting: start it with no bubble
              w_out_stream_nxt = r_mem[~r_rd_bank][0];
              w_out_first_nxt  = 1'b1;
              w_out_last_nxt   = LP_SINGLE;
              w_rd_idx_nxt     = LP_ONE;
            end else begin
              w_out_valid_nxt = 1'b0;
              w_out_first_nxt = 1'b0;
              w_out_last_nxt  = 1'b0;
              w_state_nxt     = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Frame data write; contents need no reset because the bitmaps gate validity
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately left out of reset so it maps onto
    // plain RAM/register files; nothing reads a slot before it is written.
    if (w_wr_en) r_mem[r_wr_bank][w_in_idx] <= in_stream;
  end

  // Collection state: bitmaps, bank ownership, full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitmap[0] <= '0;
      r_bitmap[1] <= '0;
      r_bank_full <= '0;
      r_wr_bank   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      r_bank_full <= w_bank_full_nxt;
      if (w_complete) begin
        r_bitmap[r_wr_bank] <= '0;
        r_wr_bank           <= ~r_wr_bank;
      end else if (w_wr_en) begin
        r_bitmap[r_wr_bank] <= w_cur_bitmap | w_id_mask;
      end
    end
  end

  // Read FSM state and registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_idx     <= '0;
      r_out_stream <= '0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_rd_idx     <= w_rd_idx_nxt;
      r_out_stream <= w_out_stream_nxt;
      r_out_first  <= w_out_first_nxt;
      r_out_last   <= w_out_last_nxt;
      r_out_valid  <= w_out_valid_nxt;
    end
  end

  // Sticky error flags; clear_err wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_range    <= 1'b0;
      r_err_dup      <= 1'b0;
      r_err_overflow <= 1'b0;
    end else if (clear_err) begin
      r_err_range    <= 1'b0;
      r_err_dup      <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_range    <= r_err_range    | w_set_range;
      r_err_dup      <= r_err_dup      | w_set_dup;
      r_err_overflow <= r_err_overflow | w_set_ovf;
    end
  end

  assign out_stream   = r_out_stream;
  assign out_first    = r_out_first;
  assign out_last     = r_out_last;
  assign out_valid    = r_out_valid;
  assign err_range    = r_err_range;
  assign err_dup      = r_err_dup;
  assign err_overflow = r_err_overflow;

endmodule

// File: doc/conv_layer_output_collector.md
Name: conv_layer_output_collector

Overview:
- Sits directly downstream of the flat-fanout convolutional neuron layer.
- Accepts that layer's sparse, out-of-order (id, value) output beats and collects one frame of LAYER_SIZE neuron results in id order.
- Replays each frame as an ordered first/last-marked feature stream for the next layer.
- Double-buffered, so collection of frame k+1 overlaps draining of frame k.

Parameters:
- LAYER_SIZE, 10: neurons per frame; valid ids are 1..LAYER_SIZE.
- LAYER_SIZE_ORDER, 4: width of id fields; 2**LAYER_SIZE_ORDER > LAYER_SIZE.
- OUTPUT_WIDTH, 8: data width, in and out.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_stream  in  OUTPUT_WIDTH  neuron result from upstream layer.
- in_id  in  LAYER_SIZE_ORDER  neuron id of in_stream (1..LAYER_SIZE).
- in_valid  in  1  in_stream/in_id valid this cycle. No backpressure: upstream cannot stall.
- out_stream  out  OUTPUT_WIDTH  ordered feature value.
- out_first  out  1  marks id 1 beat of a frame.
- out_last  out  1  marks id LAYER_SIZE beat of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts; beat transfers when out_valid && out_ready.
- clear_err  in  1  synchronous clear of all sticky error flags.
- err_range  out  1  sticky: in_id of 0 or > LAYER_SIZE was received.
- err_dup  out  1  sticky: id already present in the collecting bank.
- err_overflow  out  1  sticky: input arrived while both banks were full.

Behaviour:
- Storage: two banks, 0 and 1, each holding LAYER_SIZE x OUTPUT_WIDTH values, plus a LAYER_SIZE-bit received bitmap per bank.
- State registers: wr_bank, rd_bank, bank_full[1:0], rd_idx, draining.
- Reset (async assert, sync release): all outputs 0, bitmaps 0, bank_full 0, wr_bank=rd_bank=0, draining=0.
  - Reset mid-collect or mid-drain discards all frames.
  - Bank data contents are don't-care.

Write side (evaluated each cycle with in_valid=1), in priority order:
1. in_id==0 or in_id>LAYER_SIZE: drop the beat, set err_range.
2. bank_full[wr_bank]=1: drop the beat, set err_overflow.
3. bitmap[wr_bank][in_id]=1: drop the beat, set err_dup. The first-written value is kept.
4. Otherwise write the data and set the bitmap bit.
   - If this sets the last missing bit: bank_full[wr_bank]<=1, the bitmap is cleared, and wr_bank toggles, all in the same edge.
   - The bank becomes readable on the next cycle.

Read side FSM (IDLE / DRAIN):
- IDLE:
  - If bank_full[rd_bank]=1, load out_stream=bank[rd_bank][1], out_first=1, out_last=(LAYER_SIZE==1), out_valid=1.
  - Set rd_idx=1 and go to DRAIN.
  - Latency: the completing write at edge N gives out_valid=1 after edge N+1.
- DRAIN, on handshake:
  - If rd_idx<LAYER_SIZE: rd_idx++, present the next value; out_first=0; out_last=(rd_idx+1==LAYER_SIZE).
  - If rd_idx==LAYER_SIZE: bank_full[rd_bank]<=0 and rd_bank toggles.
    - If the other bank is already full, its id 1 beat is presented on the very next cycle (no bubble); stay in DRAIN.
    - Otherwise out_valid<=0 and go to IDLE.
- Without a handshake, out_stream, out_first, out_last and out_valid hold stable. out_valid never deasserts before the handshake.

Simultaneous events:
- The write-side bank completion and the read-side bank release in the same cycle are independent; both updates take effect.
- A write into bank B and the release of bank B in the same cycle cannot occur, because of the write-side full check.
- clear_err has priority over a same-cycle error set: flags read 0 on the next cycle.

Error flags:
- Set on the edge after the offending beat.
- Stay sticky until clear_err or reset.

Test Plan:
- LAYER_SIZE=10, out_ready=1: ids 10,9,..,1 with data 0xA0+id, one per cycle -> 10 consecutive out beats carry 0xA1..0xAA. out_first on the 0xA1 beat, out_last on the 0xAA beat. First out_valid two cycles after the id 1 write.
- Two frames back-to-back at in_valid=1, out_ready=0 until both complete, then out_ready=1 -> 20 contiguous beats with no bubble. Frame 1 data, then frame 2 data. No errors.
- out_ready toggling 1/0 every cycle during a drain -> each value held while not ready. 10 unique beats; first/last placement correct.
- Third frame sent while two are full -> its beats dropped, err_overflow=1. After clear_err, err_overflow=0. Once a bank drains, the next full frame collects normally.
- id 3 sent twice (0x11 then 0x22), plus id 0 and id 12 -> err_dup=1 and err_range=1. The drained id 3 value is 0x11.
- rst_n pulsed low mid-drain (after beat 4) -> out_valid=0 immediately. All flags 0. A subsequent full frame drains from id 1 correctly.
